rgb2gray_stat: RTL and testbench

RGB2GRAY_STAT -- requirements
Module: rgb2gray_stat

---
 rtl/rgb2gray_stat.sv | 187 ++++++++++++++++++
 tb/tb_rgb2gray_stat.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_stat.sv
// rgb2gray_stat: RGB -> luma converter with output modes and per-frame min/max.
//   Luma is a rounded fixed-point weighted sum computed over a 3-stage pipeline.
//   The result is saturated, cut down to its OUT_W MSBs, and then passed through
//   the active mode (pass, invert, threshold, inverted threshold).
//   The mode/threshold pair is latched only on an input vsync rising edge.
//   Running min/max of valid output pixels is published on each output vsync
//   rising edge.
// Ports:
//   clk, iRST                    clock, synchronous active-high reset
//   i_r/i_g/i_b                  pixel components (DATA_W each)
//   i_h_sync/i_v_sync/i_data_en  input video timing
//   i_mode, i_thresh             requested output mode / binarisation threshold
//   o_y                          processed pixel (OUT_W), 3 cycles after input
//   o_h_sync/o_v_sync/o_data_en  timing aligned with o_y
//   o_frame_min/o_frame_max      statistics of the last completed frame
//   o_stat_valid                 one-cycle pulse when the statistics update
module rgb2gray_stat #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 10,
  parameter int FRAC_W = 8,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic              clk,
  input  logic              iRST,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_h_sync,
  input  logic              i_v_sync,
  input  logic              i_data_en,
  input  logic [1:0]        i_mode,
  input  logic [OUT_W-1:0]  i_thresh,
  output logic [OUT_W-1:0]  o_y,
  output logic              o_h_sync,
  output logic              o_v_sync,
  output logic              o_data_en,
  output logic [OUT_W-1:0]  o_frame_min,
  output logic [OUT_W-1:0]  o_frame_max,
  output logic              o_stat_valid
);
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;
  localparam int FW = PW + 2;
  localparam logic [COEF_W-1:0] CR   = COEF_W'(COEF_R);
  localparam logic [COEF_W-1:0] CG   = COEF_W'(COEF_G);
  localparam logic [COEF_W-1:0] CB   = COEF_W'(COEF_B);
  localparam logic [SW-1:0]     RND  = SW'(1) << (FRAC_W - 1);
  localparam logic [FW-1:0]     YMAX = {{(FW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [OUT_W-1:0]  ONES = '1;
  localparam logic [OUT_W-1:0]  HALF = OUT_W'(1) << (OUT_W - 1);

  logic              vs_in_prev_q, vs_in_prev_d;
  logic [1:0]        act_mode_q, act_mode_d;
  logic [OUT_W-1:0]  act_thr_q, act_thr_d;
  logic [PW-1:0]     prod_r_q, prod_r_d, prod_g_q, prod_g_d, prod_b_q, prod_b_d;
  logic [1:0]        mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic [OUT_W-1:0]  thr_s1_q, thr_s1_d, thr_s2_q, thr_s2_d;
  logic [SW-1:0]     sum_rg_q, sum_rg_d, sum_b_q, sum_b_d;
  logic [2:0]        hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, de_pipe_q, de_pipe_d;
  logic [OUT_W-1:0]  o_y_q, o_y_d;
  logic [OUT_W-1:0]  frame_min_q, frame_min_d, frame_max_q, frame_max_d;
  logic [OUT_W-1:0]  run_min_q, run_min_d, run_max_q, run_max_d;
  logic              stat_valid_q, stat_valid_d;

  logic              vs_edge_in, out_edge;
  logic [1:0]        mode_in;
  logic [OUT_W-1:0]  thr_in, g_val;
  logic [FW-1:0]     final_sum, y_wide;
  logic [DATA_W-1:0] y_sat;

  always_comb begin
    // Pair latched on the input edge applies to the pixel of that same cycle.
    vs_edge_in   = i_v_sync & ~vs_in_prev_q;
    mode_in      = vs_edge_in ? i_mode   : act_mode_q;
    thr_in       = vs_edge_in ? i_thresh : act_thr_q;
    vs_in_prev_d = i_v_sync;
    act_mode_d   = mode_in;
    act_thr_d    = thr_in;

    // S1: products
    prod_r_d  = {{COEF_W{1'b0}}, i_r} * {{DATA_W{1'b0}}, CR};
    prod_g_d  = {{COEF_W{1'b0}}, i_g} * {{DATA_W{1'b0}}, CG};
    prod_b_d  = {{COEF_W{1'b0}}, i_b} * {{DATA_W{1'b0}}, CB};
    mode_s1_d = mode_in;
    thr_s1_d  = thr_in;

    // S2: partial sums, rounding constant folded into the blue term
    sum_rg_d  = {1'b0, prod_r_q} + {1'b0, prod_g_q};
    sum_b_d   = {1'b0, prod_b_q} + RND;
    mode_s2_d = mode_s1_q;
    thr_s2_d  = thr_s1_q;

    // S3: final sum, saturate, keep MSBs, apply mode
    final_sum = {1'b0, sum_rg_q} + {1'b0, sum_b_q};
    y_wide    = final_sum >> FRAC_W;
    y_sat     = (y_wide > YMAX) ? {DATA_W{1'b1}} : y_wide[DATA_W-1:0];
    g_val     = y_sat[DATA_W-1 -: OUT_W];
    case (mode_s2_q)
      2'b00:   o_y_d = g_val;
      2'b01:   o_y_d = ONES - g_val;
      2'b10:   o_y_d = (g_val >= thr_s2_q) ? ONES : '0;
      default: o_y_d = (g_val >= thr_s2_q) ? '0 : ONES;
    endcase

    hs_pipe_d = {hs_pipe_q[1:0], i_h_sync};
    vs_pipe_d = {vs_pipe_q[1:0], i_v_sync};
    de_pipe_d = {de_pipe_q[1:0], i_data_en};

    // Output vsync edge seen one stage early so the stats land on the same
    // cycle o_v_sync rises; the pixel entering o_y then opens the new frame.
    out_edge     = vs_pipe_q[1] & ~vs_pipe_q[2];
    frame_min_d  = frame_min_q;
    frame_max_d  = frame_max_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    stat_valid_d = 1'b0;
    if (out_edge) begin
      frame_min_d  = run_min_q;
      frame_max_d  = run_max_q;
      stat_valid_d = 1'b1;
      run_min_d    = de_pipe_q[1] ? o_y_d : ONES;
      run_max_d    = de_pipe_q[1] ? o_y_d : '0;
    end else if (de_pipe_q[1]) begin
      if (o_y_d < run_min_q) run_min_d = o_y_d;
      if (o_y_d > run_max_q) run_max_d = o_y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (iRST) begin
      vs_in_prev_q <= 1'b0;
      act_mode_q   <= 2'b00;
      act_thr_q    <= HALF;
      prod_r_q     <= '0;
      prod_g_q     <= '0;
      prod_b_q     <= '0;
      mode_s1_q    <= '0;
      thr_s1_q     <= '0;
      mode_s2_q    <= '0;
      thr_s2_q     <= '0;
      sum_rg_q     <= '0;
      sum_b_q      <= '0;
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      de_pipe_q    <= '0;
      o_y_q        <= '0;
      frame_min_q  <= '0;
      frame_max_q  <= '0;
      run_min_q    <= ONES;
      run_max_q    <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      vs_in_prev_q <= vs_in_prev_d;
      act_mode_q   <= act_mode_d;
      act_thr_q    <= act_thr_d;
      prod_r_q     <= prod_r_d;
      prod_g_q     <= prod_g_d;
      prod_b_q     <= prod_b_d;
      mode_s1_q    <= mode_s1_d;
      thr_s1_q     <= thr_s1_d;
      mode_s2_q    <= mode_s2_d;
      thr_s2_q     <= thr_s2_d;
      sum_rg_q     <= sum_rg_d;
      sum_b_q      <= sum_b_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      de_pipe_q    <= de_pipe_d;
      o_y_q        <= o_y_d;
      frame_min_q  <= frame_min_d;
      frame_max_q  <= frame_max_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign o_y          = o_y_q;
  assign o_h_sync     = hs_pipe_q[2];
  assign o_v_sync     = vs_pipe_q[2];
  assign o_data_en    = de_pipe_q[2];
  assign o_frame_min  = frame_min_q;
  assign o_frame_max  = frame_max_q;
  assign o_stat_valid = stat_valid_q;
endmodule

// File: tb/tb_rgb2gray_stat.sv
// Bench for rgb2gray_stat: directed spec scenarios followed by random traffic,
// all checked cycle by cycle against an arithmetic reference model. A second
// instance with a heavier green weight exercises luma saturation.
module tb_rgb2gray_stat;
  logic        clk = 1'b0;
  logic        iRST;
  logic [11:0] i_r, i_g, i_b;
  logic        i_h_sync, i_v_sync, i_data_en;
  logic [1:0]  i_mode;
  logic [7:0]  i_thresh;
  logic [7:0]  o_y, o_frame_min, o_frame_max;
  logic        o_h_sync, o_v_sync, o_data_en, o_stat_valid;
  logic [7:0]  s_y, s_fmin, s_fmax;
  logic        s_hs, s_vs, s_de, s_sv;

  always #5 clk = ~clk;

  rgb2gray_stat u_dut (
    .clk(clk), .iRST(iRST), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
    .i_mode(i_mode), .i_thresh(i_thresh), .o_y(o_y),
    .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_data_en(o_data_en),
    .o_frame_min(o_frame_min), .o_frame_max(o_frame_max), .o_stat_valid(o_stat_valid)
  );

  rgb2gray_stat #(.COEF_G(200)) u_sat (
    .clk(clk), .iRST(iRST), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
    .i_mode(i_mode), .i_thresh(i_thresh), .o_y(s_y),
    .o_h_sync(s_hs), .o_v_sync(s_vs), .o_data_en(s_de),
    .o_frame_min(s_fmin), .o_frame_max(s_fmax), .o_stat_valid(s_sv)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic [7:0] y;
    logic [7:0] ys;
    logic       hs, vs, de;
  } ent_t;

  ent_t       pq[$];
  ent_t       cur;
  logic [1:0] m_mode;
  logic [7:0] m_thr, m_fmin, m_fmax, m_rmin, m_rmax;
  logic       m_pivs, m_povs, m_sv;

  function automatic logic [7:0] gray(input int rr, input int gg, input int bb,
                                      input int cg, input logic [1:0] md,
                                      input logic [7:0] th);
    int y;
    logic [7:0] v;
    y = (rr * 77 + gg * cg + bb * 29 + 128) / 256;
    if (y > 4095) y = 4095;
    v = 8'(y / 16);
    case (md)
      2'd0:    return v;
      2'd1:    return 8'd255 - v;
      2'd2:    return (v >= th) ? 8'd255 : 8'd0;
      default: return (v >= th) ? 8'd0 : 8'd255;
    endcase
  endfunction

  task automatic step();
    ent_t e;
    @(posedge clk);
    if (iRST) begin
      pq.delete();
      e = '{y: 8'd0, ys: 8'd0, hs: 1'b0, vs: 1'b0, de: 1'b0};
      pq.push_back(e);
      pq.push_back(e);
      cur = e;
      m_mode = 2'd0; m_thr = 8'd128; m_pivs = 1'b0; m_povs = 1'b0;
      m_fmin = 8'd0; m_fmax = 8'd0; m_sv = 1'b0; m_rmin = 8'd255; m_rmax = 8'd0;
    end else begin
      if (i_v_sync && !m_pivs) begin
        m_mode = i_mode;
        m_thr  = i_thresh;
      end
      m_pivs = i_v_sync;
      e.y  = gray(int'(i_r), int'(i_g), int'(i_b), 150, m_mode, m_thr);
      e.ys = gray(int'(i_r), int'(i_g), int'(i_b), 200, m_mode, m_thr);
      e.hs = i_h_sync; e.vs = i_v_sync; e.de = i_data_en;
      pq.push_back(e);
      cur  = pq.pop_front();
      m_sv = 1'b0;
      if (cur.vs && !m_povs) begin
        m_fmin = m_rmin; m_fmax = m_rmax; m_sv = 1'b1;
        m_rmin = cur.de ? cur.y : 8'd255;
        m_rmax = cur.de ? cur.y : 8'd0;
      end else if (cur.de) begin
        if (cur.y < m_rmin) m_rmin = cur.y;
        if (cur.y > m_rmax) m_rmax = cur.y;
      end
      m_povs = cur.vs;
    end
    #1;
    chk("y", o_y, cur.y);
    chk("ysat", s_y, cur.ys);
    chk("sync", {o_h_sync, o_v_sync, o_data_en}, {cur.hs, cur.vs, cur.de});
    chk("fmin", o_frame_min, m_fmin);
    chk("fmax", o_frame_max, m_fmax);
    chk("stat_valid", o_stat_valid, m_sv);
  endtask

  task automatic drive(input int rv, input int gv, input int bv, input logic d);
    i_r = 12'(rv); i_g = 12'(gv); i_b = 12'(bv); i_data_en = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1'b0);
  endtask

  // Equal components X give Y = X, so g = X/16.
  task automatic pix(input int v);
    drive(v * 16, v * 16, v * 16, 1'b1);
  endtask

  initial begin
    iRST = 1'b1; i_h_sync = 1'b0; i_v_sync = 1'b0; i_mode = 2'd0; i_thresh = 8'd0;
    idle();
    step(); step();
    chk("rst_y", o_y, 0);
    chk("rst_sv", o_stat_valid, 0);
    iRST = 1'b0;

    // Latency and full-scale white; saturating instance must not wrap.
    drive(4095, 4095, 4095, 1'b1); step();
    idle(); step();
    chk("lat_de_early", o_data_en, 0);
    step();
    chk("lat_y", o_y, 255);
    chk("lat_de", o_data_en, 1);
    chk("sat_y", s_y, 255);

    // Red only
    drive(4095, 0, 0, 1'b1); step();
    idle(); step(); step();
    chk("r_only", o_y, 77);

    // Binarisation, pair latched on the vsync edge pixel itself
    i_mode = 2'd2; i_thresh = 8'd77; i_v_sync = 1'b1;
    drive(4095, 0, 0, 1'b1); step();
    i_v_sync = 1'b0;
    drive(4094, 0, 0, 1'b1); step();
    i_thresh = 8'd200;
    drive(4095, 0, 0, 1'b1); step();
    chk("bin_hi", o_y, 255);
    idle(); step();
    chk("bin_lo", o_y, 0);
    step();
    chk("bin_hold", o_y, 255);
    i_v_sync = 1'b1;
    drive(4095, 0, 0, 1'b1); step();
    i_v_sync = 1'b0;
    idle(); step(); step();
    chk("bin_new", o_y, 0);

    // Frame statistics
    i_mode = 2'd0; i_v_sync = 1'b1; idle(); step();
    i_v_sync = 1'b0;
    pix(10); step();
    pix(200); step();
    pix(55); step();
    idle(); step();
    i_v_sync = 1'b1; step();
    i_v_sync = 1'b0; step(); step();
    chk("st_valid", o_stat_valid, 1);
    chk("st_min", o_frame_min, 10);
    chk("st_max", o_frame_max, 200);
    step();
    chk("st_pulse", o_stat_valid, 0);
    step(); step();
    i_v_sync = 1'b1; step();
    i_v_sync = 1'b0; step(); step();
    chk("empty_min", o_frame_min, 255);
    chk("empty_max", o_frame_max, 0);
    chk("empty_valid", o_stat_valid, 1);

    // Reset mid-frame
    i_mode = 2'd3; i_v_sync = 1'b1; idle(); step();
    i_v_sync = 1'b0; i_mode = 2'd0;
    pix(5); step();
    pix(5); step();
    pix(5); step();
    iRST = 1'b1; step();
    iRST = 1'b0;
    chk("mid_rst_y", o_y, 0);
    chk("mid_rst_de", o_data_en, 0);
    pix(100); step();
    pix(120); step();
    idle(); step();
    chk("rst_mode0", o_y, 100);
    i_v_sync = 1'b1; step();
    i_v_sync = 1'b0; step(); step();
    chk("rst_min", o_frame_min, 100);
    chk("rst_max", o_frame_max, 120);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      i_r       = 12'($urandom_range(0, 4095));
      i_g       = 12'($urandom_range(0, 4095));
      i_b       = 12'($urandom_range(0, 4095));
      i_data_en = ($urandom_range(0, 3) != 0);
      i_h_sync  = ($urandom_range(0, 7) == 0);
      i_v_sync  = ($urandom_range(0, 30) == 0);
      i_mode    = 2'($urandom_range(0, 3));
      i_thresh  = 8'($urandom_range(0, 255));
      iRST      = ($urandom_range(0, 250) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
